// File: rtl/parc_pkg.sv
// Shared types and grant encodings for the PARC memory arbiter.
package parc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/parc_arb_pick.sv
// Combinational winner selection for the arbiter.
// PARC_ARB_RR_EN selects round-robin; otherwise dmem priority with a fetch starvation guard.
module parc_arb_pick
    import parc_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       imem_req,
    input  logic       dmem_req,
    input  logic [3:0] wait_cnt,
    input  logic       rr_ptr,
    output logic [1:0] pick
);

    logic imem_first;

`ifdef PARC_ARB_RR_EN
    logic unused_wait_cnt;
    assign unused_wait_cnt = ^wait_cnt;
    // rr_ptr == 0 names imem as the port with priority
    assign imem_first = ~rr_ptr;
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;
    assign imem_first = (wait_cnt >= 4'(STARVE_LIMIT));
`endif

    always_comb begin
        pick = GRANT_NONE;
        if (imem_req && dmem_req) begin
            pick = imem_first ? GRANT_I : GRANT_D;
        end else if (imem_req) begin
            pick = GRANT_I;
        end else if (dmem_req) begin
            pick = GRANT_D;
        end
    end

endmodule

// File: rtl/parc_mem_arbiter.sv
// Shares one memory port between PARC instruction fetch and data access.
// Define PARC_ARB_RR_EN for round-robin arbitration instead of dmem priority.
module parc_mem_arbiter
    import parc_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] imem_addr,
    input  logic            imem_req,
    output logic [XLEN-1:0] imem_data,
    output logic            imem_resp,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_we,
    input  logic            dmem_req,
    output logic [XLEN-1:0] dmem_data,
    output logic            dmem_resp,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    output logic            mem_req,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_resp,
    output logic [1:0]      grant
);

    arb_state_e      state_q, state_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            rr_ptr_q, rr_ptr_d;
    logic [1:0]      pick;
    logic            load_i, load_d;

    parc_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .wait_cnt (wait_cnt_q),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        imem_resp   = 1'b0;
        dmem_resp   = 1'b0;
        imem_data   = '0;
        dmem_data   = '0;
        load_i      = 1'b0;
        load_d      = 1'b0;
        case (state_q)
            IDLE: begin
                load_i = (pick == GRANT_I);
                load_d = (pick == GRANT_D);
            end
            BUSY_I: begin
                if (mem_resp) begin
                    imem_resp = 1'b1;
                    imem_data = mem_rdata;
                    state_d   = IDLE;
                    load_d    = dmem_req;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    dmem_resp = 1'b1;
                    dmem_data = mem_rdata;
                    state_d   = IDLE;
                    load_i    = imem_req;
                end
            end
            default: state_d = IDLE;
        endcase
        // Fetches are always reads, so the store fields are zeroed
        if (load_i) begin
            state_d     = BUSY_I;
            mem_addr_d  = imem_addr;
            mem_wdata_d = '0;
            mem_we_d    = 1'b0;
        end
        if (load_d) begin
            state_d     = BUSY_D;
            mem_addr_d  = dmem_addr;
            mem_wdata_d = dmem_wdata;
            mem_we_d    = dmem_we;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        rr_ptr_d   = rr_ptr_q;
`ifdef PARC_ARB_RR_EN
        wait_cnt_d = '0;
        if (imem_resp || dmem_resp) begin
            rr_ptr_d = ~rr_ptr_q;
        end
`else
        if (load_i) begin
            wait_cnt_d = '0;
        end else if (imem_req && (state_q != BUSY_I) && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            wait_cnt_q  <= '0;
            rr_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            wait_cnt_q  <= wait_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_req   = (state_q != IDLE);
    assign grant     = (state_q == BUSY_I) ? GRANT_I :
                       (state_q == BUSY_D) ? GRANT_D : GRANT_NONE;

endmodule

// File: tb/tb_parc_mem_arbiter.sv
// Directed self-checking bench for parc_mem_arbiter in its default fixed-priority build.
module tb_parc_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic        dmem_req;
    logic [31:0] dmem_data;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [1:0]  grant;

    int n_assert = 0;
    int n_fail   = 0;

    parc_mem_arbiter #(
        .XLEN(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_data  (imem_data),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_req   (dmem_req),
        .dmem_data  (dmem_data),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_req    (mem_req),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  waited;
    bit  got;

    initial begin
        rst_n      = 1'b0;
        imem_addr  = '0;
        imem_req   = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        dmem_req   = 1'b0;
        mem_rdata  = '0;
        mem_resp   = 1'b0;
        #2;
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_grant",     32'(grant),     32'd0);
        chk("rst_resps",     32'({imem_resp, dmem_resp}), 32'd0);
        chk("rst_datas",     imem_data | dmem_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single load
        dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h100;
        tick();
        chk("ld_mem_req",  32'(mem_req),   32'd1);
        chk("ld_grant",    32'(grant),     32'b10);
        chk("ld_mem_addr", mem_addr,       32'h100);
        chk("ld_mem_we",   32'(mem_we),    32'd0);
        chk("ld_no_resp",  32'(dmem_resp), 32'd0);
        mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_dresp",    32'(dmem_resp), 32'd1);
        chk("ld_ddata",    dmem_data,      32'hDEADBEEF);
        chk("ld_iresp",    32'(imem_resp), 32'd0);
        chk("ld_idata",    imem_data,      32'd0);
        dmem_req = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        chk("ld_idle_req",   32'(mem_req),   32'd0);
        chk("ld_idle_grant", 32'(grant),     32'd0);
        chk("ld_idle_dresp", 32'(dmem_resp), 32'd0);

        // simultaneous requests: dmem first, imem back-to-back
        imem_req = 1'b1; imem_addr = 32'h8000_0000;
        dmem_req = 1'b1; dmem_addr = 32'h200; dmem_wdata = 32'hAAAA_5555;
        tick();
        chk("sim_grant_d", 32'(grant),   32'b10);
        chk("sim_addr_d",  mem_addr,     32'h200);
        chk("sim_req_d",   32'(mem_req), 32'd1);
        mem_resp = 1'b1; mem_rdata = 32'h1111_1111;
        #1;
        chk("sim_dresp",   32'(dmem_resp), 32'd1);
        chk("sim_iresp0",  32'(imem_resp), 32'd0);
        dmem_req = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        chk("sim_grant_i", 32'(grant),   32'b01);
        chk("sim_req_i",   32'(mem_req), 32'd1);
        chk("sim_addr_i",  mem_addr,     32'h8000_0000);
        chk("sim_we_i",    32'(mem_we),  32'd0);
        chk("sim_wdata_i", mem_wdata,    32'd0);
        mem_resp = 1'b1; mem_rdata = 32'h2222_2222;
        #1;
        chk("sim_iresp",   32'(imem_resp), 32'd1);
        chk("sim_idata",   imem_data,      32'h2222_2222);
        chk("sim_dresp0",  32'(dmem_resp), 32'd0);
        chk("sim_ddata0",  dmem_data,      32'd0);
        imem_req = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        chk("sim_idle", 32'({mem_req, grant}), 32'd0);

        // store with a two-cycle memory
        dmem_req = 1'b1; dmem_we = 1'b1; dmem_wdata = 32'h1234_5678; dmem_addr = 32'h40;
        tick();
        chk("st_we",    32'(mem_we),  32'd1);
        chk("st_wdata", mem_wdata,    32'h1234_5678);
        chk("st_addr",  mem_addr,     32'h40);
        tick();
        chk("st_hold_req",  32'(mem_req),   32'd1);
        chk("st_hold_we",   32'(mem_we),    32'd1);
        chk("st_wait_resp", 32'(dmem_resp), 32'd0);
        mem_resp = 1'b1; mem_rdata = 32'h0;
        #1;
        chk("st_dresp", 32'(dmem_resp), 32'd1);
        dmem_req = 1'b0; dmem_we = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        chk("st_idle_req", 32'(mem_req), 32'd0);

        // starvation guard: dmem keeps re-requesting while imem is held
        imem_req = 1'b1; imem_addr = 32'h500;
        dmem_req = 1'b1; dmem_addr = 32'h600;
        waited = 0; got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            mem_resp = 1'b0;
            waited++;
            if (grant == 2'b01) begin
                got = 1'b1;
            end else if (grant == 2'b10) begin
                mem_resp = 1'b1; mem_rdata = 32'h3333_3333;
                #1;
            end
        end
        chk("starve_grant",   32'(grant), 32'b01);
        chk("starve_latency", 32'(waited <= 5), 32'd1);
        chk("starve_addr",    mem_addr, 32'h500);
        mem_resp = 1'b1; mem_rdata = 32'h4444_4444;
        #1;
        chk("starve_iresp", 32'(imem_resp), 32'd1);
        imem_req = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        chk("starve_d_again", 32'(grant), 32'b10);
        mem_resp = 1'b1;
        #1;
        dmem_req = 1'b0;
        tick();
        mem_resp = 1'b0;
        #1;
        chk("starve_idle", 32'({mem_req, grant}), 32'd0);

        // mem_resp while idle is ignored
        mem_resp = 1'b1; mem_rdata = 32'h5555_5555;
        #1;
        chk("idle_resp", 32'({imem_resp, dmem_resp}), 32'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        chk("idle_resp_req", 32'({mem_req, grant}), 32'd0);

        // reset asserted mid-fetch, then a stale mem_resp
        imem_req = 1'b1; imem_addr = 32'h300;
        tick();
        chk("rst_mid_grant", 32'(grant), 32'b01);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req",   32'(mem_req),   32'd0);
        chk("rst_mid_grant0", 32'(grant),    32'd0);
        chk("rst_mid_iresp", 32'(imem_resp), 32'd0);
        imem_req = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_resp = 1'b1; mem_rdata = 32'h6666_6666;
        #1;
        chk("stale_iresp", 32'(imem_resp), 32'd0);
        chk("stale_idata", imem_data,      32'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        chk("stale_idle", 32'({mem_req, grant}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
